// File: rtl/alu_cmd_driver_if.sv
// Request/response and alu-side signal bundle for alu_cmd_driver, plus the alu command codes.
// master = driver side, slave = requester/consumer/alu side.
`ifndef ALU_CMD_DEFS_VH
`define ALU_CMD_DEFS_VH
`define ADD 4'h0
`define SUB 4'h1
`define MUL 4'h2
`define DIV 4'h3
`define INC 4'h4
`define DEC 4'h5
`define SHL 4'h6
`define SHR 4'h7
`define AND 4'h8
`define OR  4'h9
`define XOR 4'hA
`define NOT 4'hB
`define BUF 4'hC
`endif

interface alu_cmd_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        alu_oe;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport master (
    input  req_valid, req_cmd, req_a, req_b, alu_d, rsp_ready,
    output req_ready, alu_oe, alu_cmd, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    output req_valid, req_cmd, req_a, req_b, alu_d, rsp_ready,
    input  req_ready, alu_oe, alu_cmd, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Initiator for a combinational alu: one operation in flight, operands held with alu_oe
// for SETTLE_CYCLES cycles, result captured and returned over a valid/ready response.
module alu_cmd_driver #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_driver_if.master  bus
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             alu_oe_q;
  logic [3:0]       alu_cmd_q;
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_data_q;
  logic             rsp_err_q;
  logic             reject_c;

  // Divide by zero is answered locally without ever enabling the alu.
  always_comb begin
    reject_c = 1'b0;
    if ((bus.req_cmd == `DIV) && (bus.req_b == 8'h00)) reject_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_oe_q    <= 1'b0;
      alu_cmd_q   <= 4'h0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            alu_cmd_q <= bus.req_cmd;
            alu_a_q   <= bus.req_a;
            alu_b_q   <= bus.req_b;
            if (reject_c) begin
              rsp_data_q  <= 16'hFFFF;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              alu_oe_q  <= 1'b1;
              cnt_q     <= '0;
              rsp_err_q <= 1'b0;
              state_q   <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= bus.alu_d;
            alu_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // req_ready is held low while reset is asserted so nothing is offered into a clearing block.
  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.alu_oe    = alu_oe_q;
  assign bus.alu_cmd   = alu_cmd_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: a behavioural alu drives alu_d, two builds
// (SETTLE_CYCLES=2 and =1) are exercised with hand-computed results.
`timescale 1ns/1ps
`ifndef ALU_CMD_DEFS_VH
`define ALU_CMD_DEFS_VH
`define ADD 4'h0
`define SUB 4'h1
`define MUL 4'h2
`define DIV 4'h3
`define INC 4'h4
`define DEC 4'h5
`define SHL 4'h6
`define SHR 4'h7
`define AND 4'h8
`define OR  4'h9
`define XOR 4'hA
`define NOT 4'hB
`define BUF 4'hC
`endif

module tb_alu_cmd_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  alu_cmd_driver_if ifa ();
  alu_cmd_driver_if ifb ();

  alu_cmd_driver #(.SETTLE_CYCLES(2)) u_dut  (.clk(clk), .rst(rst), .bus(ifa.master));
  alu_cmd_driver #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifb.master));

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      `ADD: return 16'(a) + 16'(b);
      `SUB: return 16'(a) - 16'(b);
      `MUL: return 16'(a) * 16'(b);
      `DIV: return (b == 8'h00) ? 16'hFFFF : 16'(a / b);
      `INC: return 16'(a) + 16'h0001;
      `DEC: return 16'(a) - 16'h0001;
      `SHL: return 16'(a) << b;
      `SHR: return 16'(a >> b);
      `AND: return {8'h00, a & b};
      `OR:  return {8'h00, a | b};
      `XOR: return {8'h00, a ^ b};
      `NOT: return {8'h00, ~a};
      `BUF: return {8'h00, a};
      default: return 16'h0000;
    endcase
  endfunction

  // Poison value while disabled so an early sample shows up in rsp_data.
  assign ifa.alu_d = ifa.alu_oe ? alu_model(ifa.alu_cmd, ifa.alu_a, ifa.alu_b) : 16'hDEAD;
  assign ifb.alu_d = ifb.alu_oe ? alu_model(ifb.alu_cmd, ifb.alu_a, ifb.alu_b) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation on the SETTLE_CYCLES=2 build; hold = cycles rsp_ready stays low.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_d, input logic exp_e, input int exp_lat, input int exp_oe,
                        input int hold);
    int  k;
    int  oe_n;
    bit  seen;
    bit  hold_ok;
    @(negedge clk);
    chk({tag, ":req_ready_idle"}, 32'(ifa.req_ready), 32'd1);
    ifa.req_valid = 1'b1;
    ifa.req_cmd   = c;
    ifa.req_a     = a;
    ifa.req_b     = b;
    ifa.rsp_ready = (hold == 0);
    @(posedge clk);
    #1 ifa.req_valid = 1'b0;
    k = 0; oe_n = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (ifa.alu_oe) oe_n++;
      if (ifa.rsp_valid) seen = 1'b1;
    end
    chk({tag, ":latency"}, 32'(k - 1), 32'(exp_lat));
    chk({tag, ":oe_cycles"}, 32'(oe_n), 32'(exp_oe));
    chk({tag, ":rsp_data"}, 32'(ifa.rsp_data), 32'(exp_d));
    chk({tag, ":rsp_err"}, 32'(ifa.rsp_err), 32'(exp_e));
    chk({tag, ":alu_cmd_ab"}, {20'h0, ifa.alu_cmd, ifa.alu_a}, {20'h0, c, a});
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      ifa.req_valid = 1'b1;
      ifa.req_cmd   = `ADD;
      ifa.req_a     = 8'hAA;
      ifa.req_b     = 8'h55;
      @(negedge clk);
      if (!ifa.rsp_valid || ifa.req_ready || ifa.rsp_data != exp_d) hold_ok = 1'b0;
    end
    if (hold > 0) chk({tag, ":held_while_stalled"}, 32'(hold_ok), 32'd1);
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ":idle_after"}, {29'h0, ifa.rsp_valid, ifa.req_ready, ifa.busy}, 32'b010);
    chk({tag, ":data_retained"}, {8'h0, ifa.rsp_data, ifa.alu_a}, {8'h0, exp_d, a});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k;
    int oe_n;
    bit seen;
    bit quiet;
    logic [3:0]  vc [2];
    logic [7:0]  va [2];
    logic [15:0] vd [2];

    ifa.req_valid = 1'b0; ifa.req_cmd = 4'h0; ifa.req_a = 8'h00; ifa.req_b = 8'h00; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_cmd = 4'h0; ifb.req_a = 8'h00; ifb.req_b = 8'h00; ifb.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {ifa.alu_oe, ifa.rsp_valid, ifa.rsp_err, ifa.busy, ifa.req_ready, 11'h0, ifa.rsp_data},
        32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_ready", 32'(ifa.req_ready), 32'd1);

    run_op("add",  `ADD, 8'h0F, 8'h01, 16'h0010, 1'b0, 2, 2, 0);
    run_op("mul",  `MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 2, 2, 0);
    run_op("div0", `DIV, 8'h10, 8'h00, 16'hFFFF, 1'b1, 0, 0, 0);
    run_op("shl",  `SHL, 8'h01, 8'h04, 16'h0010, 1'b0, 2, 2, 5);
    run_op("sub",  `SUB, 8'h05, 8'h03, 16'h0002, 1'b0, 2, 2, 0);

    // Reset in the middle of SETTLE.
    @(negedge clk);
    ifa.req_valid = 1'b1; ifa.req_cmd = `SUB; ifa.req_a = 8'h05; ifa.req_b = 8'h03; ifa.rsp_ready = 1'b1;
    @(posedge clk);
    #1 ifa.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid:oe_before", 32'(ifa.alu_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid:async_clear", {28'h0, ifa.alu_oe, ifa.rsp_valid, ifa.busy, 1'b0}, 32'h0);
    chk("rst_mid:alu_a_cleared", 32'(ifa.alu_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ifa.rsp_valid || ifa.alu_oe || !ifa.req_ready) quiet = 1'b0;
    end
    chk("rst_mid:no_response", 32'(quiet), 32'd1);

    // SETTLE_CYCLES=1 build, back-to-back.
    vc[0] = `INC; va[0] = 8'hFF; vd[0] = 16'h0100;
    vc[1] = `DEC; va[1] = 8'h00; vd[1] = 16'hFFFF;
    ifb.rsp_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      k = 0;
      while (!ifb.req_ready && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("s1_v%0d:ready_gap", v), 32'(k), (v == 0) ? 32'd0 : 32'd1);
      ifb.req_valid = 1'b1; ifb.req_cmd = vc[v]; ifb.req_a = va[v]; ifb.req_b = 8'h00;
      @(posedge clk);
      #1 ifb.req_valid = 1'b0;
      k = 0; oe_n = 0; seen = 1'b0;
      while (!seen && k < 20) begin
        @(negedge clk);
        k++;
        if (ifb.alu_oe) oe_n++;
        if (ifb.rsp_valid) seen = 1'b1;
      end
      chk($sformatf("s1_v%0d:latency", v), 32'(k - 1), 32'd1);
      chk($sformatf("s1_v%0d:oe_cycles", v), 32'(oe_n), 32'd1);
      chk($sformatf("s1_v%0d:rsp_data", v), 32'(ifb.rsp_data), 32'(vd[v]));
      chk($sformatf("s1_v%0d:rsp_err", v), 32'(ifb.rsp_err), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
